// File: rtl/mux_tree_pipeline_pkg.sv
// ---------------------------------------------------------------------------
// mux_tree_pipeline_pkg
//   Shared types and elaboration-time helpers for the pipelined mux tree.
//   - stage_hs_t   : valid/ready pair that every tree stage exports
//   - is_pow2      : legal-width check for the input word
//   - sel_width    : index width (= number of tree levels) for a word width
//   - level_offset : bit offset of a level's data slice inside the flattened
//                    data chain (level 0 = input word, last level = 1 bit)
// ---------------------------------------------------------------------------
package mux_tree_pipeline_pkg;

  // Each stage drives its own valid downstream and its ready term upstream.
  typedef struct packed {
    logic valid;
    logic ready;
  } stage_hs_t;

  function automatic bit is_pow2(int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

  function automatic int sel_width(int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Widths halve per level, so level k starts at N + N/2 + ... = 2N - 2(N>>k).
  function automatic int level_offset(int n, int k);
    return 2 * n - 2 * (n >> k);
  endfunction

endpackage

// File: rtl/mux_tree_pipeline_if.sv
// ---------------------------------------------------------------------------
// mux_tree_pipeline_if
//   Handshake bundle between the capture side and the single-bit consumer.
//   Signals:
//     flush              synchronous drop of all in-flight items
//     in_valid/in_ready  input handshake
//     in_data, in_idx    word to select from and bit index
//     out_valid/out_ready output handshake
//     out_data, out_idx  selected bit and echoed index
//   Modports:
//     master : the side that drives items in and consumes results
//     slave  : the mux tree itself
// ---------------------------------------------------------------------------
interface mux_tree_pipeline_if #(
  parameter int NUM_INPUTS = 16
);
  import mux_tree_pipeline_pkg::*;

  localparam int SEL_W = sel_width(NUM_INPUTS);

  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [NUM_INPUTS-1:0] in_data;
  logic [SEL_W-1:0]      in_idx;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_data;
  logic [SEL_W-1:0]      out_idx;

  modport master (
    output flush, in_valid, in_data, in_idx, out_ready,
    input  in_ready, out_valid, out_data, out_idx
  );

  modport slave (
    input  flush, in_valid, in_data, in_idx, out_ready,
    output in_ready, out_valid, out_data, out_idx
  );

endinterface

// File: rtl/mux_tree_pipeline_stage.sv
// ---------------------------------------------------------------------------
// mux_submodule
//   One halving mux level: z[i] = sel ? a[2i+1] : a[2i].
//   Ports: a_i (IN_W bits), sel_i (1), z_o (IN_W/2 bits)
// ---------------------------------------------------------------------------
module mux_submodule #(
  parameter int IN_W = 2
) (
  input  logic [IN_W-1:0]   a_i,
  input  logic              sel_i,
  output logic [IN_W/2-1:0] z_o
);

  always_comb begin
    z_o = '0;
    for (int i = 0; i < IN_W / 2; i++) begin
      z_o[i] = sel_i ? a_i[2*i+1] : a_i[2*i];
    end
  end

endmodule

// ---------------------------------------------------------------------------
// mux_tree_stage
//   One registered level of the tree: a mux_submodule steered by bit LEVEL of
//   the item's index, followed by valid/data/idx registers.
//   Ports:
//     clk, rst_n  clock, async active-low reset
//     flush_i     clears the stage valid (beats any load)
//     valid_i     incoming item valid from upstream
//     data_i      IN_W-bit slice from upstream
//     idx_i       full index travelling with the item
//     rdyNext_i   ready of the downstream stage (or consumer)
//     data_o      IN_W/2-bit registered slice
//     idx_o       registered index
//     hs_o        {valid_q, ready term} of this stage
// ---------------------------------------------------------------------------
module mux_tree_stage
  import mux_tree_pipeline_pkg::*;
#(
  parameter int IN_W  = 2,
  parameter int SEL_W = 1,
  parameter int LEVEL = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [IN_W-1:0]   data_i,
  input  logic [SEL_W-1:0]  idx_i,
  input  logic              rdyNext_i,
  output logic [IN_W/2-1:0] data_o,
  output logic [SEL_W-1:0]  idx_o,
  output stage_hs_t         hs_o
);

  localparam int OUT_W = IN_W / 2;

  logic             valid_q, valid_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] muxOut;
  logic             rdy;

  mux_submodule #(.IN_W(IN_W)) u_mux (
    .a_i   (data_i),
    .sel_i (idx_i[LEVEL]),
    .z_o   (muxOut)
  );

  // An empty slot always accepts, which is what collapses bubbles while the
  // consumer is stalled.
  assign rdy = !valid_q || rdyNext_i;

  // Payload registers only move when a real item arrives; an invalid slot
  // keeps its stale contents so the output stays quiet between items.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (rdy) begin
      valid_d = valid_i;
      if (valid_i) begin
        data_d = muxOut;
        idx_d  = idx_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  assign data_o     = data_q;
  assign idx_o      = idx_q;
  assign hs_o.valid = valid_q;
  assign hs_o.ready = rdy;

endmodule

// File: rtl/mux_tree_pipeline.sv
// ---------------------------------------------------------------------------
// mux_tree_pipeline
//   Registered, handshaked NUM_INPUTS:1 bit selector. SEL_W cascaded halving
//   mux stages, each with its own valid/ready register slice; throughput one
//   item per cycle, latency SEL_W cycles when unstalled.
//   Ports:
//     clk    clock, all state on the rising edge
//     rst_n  asynchronous active-low reset
//     bus    mux_tree_pipeline_if.slave (flush, in_*, out_*)
// ---------------------------------------------------------------------------
module mux_tree_pipeline
  import mux_tree_pipeline_pkg::*;
#(
  parameter int NUM_INPUTS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_tree_pipeline_if.slave   bus
);

  localparam int SEL_W   = sel_width(NUM_INPUTS);
  localparam int CHAIN_W = 2 * NUM_INPUTS - 1;

  if (!is_pow2(NUM_INPUTS)) begin : g_param_check
    $error("mux_tree_pipeline: NUM_INPUTS=%0d must be a power of two >= 2", NUM_INPUTS);
  end

  // All level data slices packed back to back: input word first, the single
  // selected bit in the top position.
  logic [CHAIN_W-1:0] dataChain;
  logic [SEL_W-1:0]   idxChain [0:SEL_W];
  stage_hs_t          hsChain  [0:SEL_W-1];
  logic               acceptIn;

  // Flush blocks acceptance so the item offered in the flush cycle is dropped.
  assign bus.in_ready = hsChain[0].ready && !bus.flush;
  assign acceptIn     = bus.in_valid && bus.in_ready;

  assign dataChain[NUM_INPUTS-1:0] = bus.in_data;
  assign idxChain[0]               = bus.in_idx;

  for (genvar k = 0; k < SEL_W; k++) begin : g_stage
    localparam int IN_W    = NUM_INPUTS >> k;
    localparam int OFF_IN  = level_offset(NUM_INPUTS, k);
    localparam int OFF_OUT = level_offset(NUM_INPUTS, k + 1);

    logic validIn;
    logic rdyNext;

    if (k == 0) begin : g_first
      assign validIn = acceptIn;
    end else begin : g_mid
      assign validIn = hsChain[k-1].valid;
    end

    if (k == SEL_W - 1) begin : g_last
      assign rdyNext = bus.out_ready;
    end else begin : g_inner
      assign rdyNext = hsChain[k+1].ready;
    end

    mux_tree_stage #(
      .IN_W  (IN_W),
      .SEL_W (SEL_W),
      .LEVEL (k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush_i   (bus.flush),
      .valid_i   (validIn),
      .data_i    (dataChain[OFF_IN +: IN_W]),
      .idx_i     (idxChain[k]),
      .rdyNext_i (rdyNext),
      .data_o    (dataChain[OFF_OUT +: IN_W/2]),
      .idx_o     (idxChain[k+1]),
      .hs_o      (hsChain[k])
    );
  end

  assign bus.out_valid = hsChain[SEL_W-1].valid;
  assign bus.out_data  = dataChain[CHAIN_W-1];
  assign bus.out_idx   = idxChain[SEL_W];

endmodule
